// File: rtl/dram_resp_pkg.sv
// dram_resp_pkg: shared constants, the store-buffer entry type and the
// lane helpers used by the DRAM responder.
package dram_resp_pkg;

  localparam int XLEN        = 32;
  localparam int DEPTH_WORDS = 4096;
  localparam int IDX_W       = $clog2(DEPTH_WORDS);

  // Unshifted size patterns driven by the core.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  data;
    logic [3:0]       be;
  } st_buf_t;

  // Replace the byte lanes of old_w selected by be with those of new_w.
  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] old_w,
                                                 input logic [XLEN-1:0] new_w,
                                                 input logic [3:0]      be);
    logic [XLEN-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Shift the size pattern to its byte offset. Returns {be_s, ovf}; ovf is
  // set when any lane falls past byte 3, i.e. the access crosses a word.
  function automatic logic [4:0] shift_check(input logic [3:0] be,
                                             input logic [1:0] off);
    logic [7:0] w;
    w = {4'b0000, be} << off;
    return {w[3:0], |w[7:4]};
  endfunction

endpackage

// File: rtl/dram_resp_ram.sv
// dram_resp_ram: word-wide RAM, one byte-enabled write port and one
// registered read port with read-before-write behaviour.
//   clk_i, rst_i   clock, synchronous active-high reset (output reg only)
//   i_we_be        per-lane write enables
//   i_wr_idx/data  write word index and data
//   i_rd_idx       read word index, sampled every cycle
//   o_rd_data      registered read word
module dram_resp_ram #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       i_we_be,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [XLEN-1:0]  i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [XLEN-1:0]  o_rd_data
);

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_q;

  // Array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (i_we_be[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
  end

  // Non-blocking read returns the pre-write contents on a same-edge write.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_q <= '0;
    else       r_q <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/dram_resp.sv
// dram_resp: data-memory responder for the core's DRAM port.
//   clk_i, rst_i              clock, synchronous active-high reset
//   dram_rd_addr_i/rd_data_o  read byte address; word returned next cycle
//   dram_wr_addr_i/data_i     store address and right-justified data
//   dram_wr_byte_en_i         unshifted size pattern (0000/0001/0011/1111)
//   host_wr_*                 preload port, valid/ready, full words only
//   misalign_o/misalign_cnt_o sticky flag / saturating count of dropped
//                             word-crossing stores
// Stores are posted into a one-entry buffer and committed the next edge;
// reads that hit the buffer take those lanes from it.
module dram_resp
  import dram_resp_pkg::*;
#(
  // The store-buffer type is sized from the package; change sizes there.
  parameter int XLEN        = dram_resp_pkg::XLEN,
  parameter int DEPTH_WORDS = dram_resp_pkg::DEPTH_WORDS
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  output logic [XLEN-1:0] dram_rd_data_o,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  input  logic            host_wr_valid_i,
  output logic            host_wr_ready_o,
  input  logic [XLEN-1:0] host_wr_addr_i,
  input  logic [XLEN-1:0] host_wr_data_i,
  output logic            misalign_o,
  output logic [7:0]      misalign_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [1:0]       w_off;
  logic [3:0]       w_be_s;
  logic             w_ovf;
  logic             w_core_act;
  logic             w_host_hs;
  logic [XLEN-1:0]  w_data_s;
  logic [IDX_W-1:0] w_rd_idx;
  logic [3:0]       w_we_be;
  logic [XLEN-1:0]  w_ram_q;
  st_buf_t          w_buf_nxt;
  st_buf_t          r_buf;
  logic [3:0]       r_fwd_be;
  logic [XLEN-1:0]  r_fwd_data;
  logic             r_mis;
  logic [7:0]       r_mis_cnt;

  assign w_off              = dram_wr_addr_i[1:0];
  assign {w_be_s, w_ovf}    = shift_check(dram_wr_byte_en_i, w_off);
  assign w_data_s           = dram_wr_data_i << {w_off, 3'b000};
  assign w_core_act         = (dram_wr_byte_en_i != BE_NONE);
  assign host_wr_ready_o    = !rst_i && !w_core_act;
  assign w_host_hs          = host_wr_valid_i && host_wr_ready_o;
  assign w_rd_idx           = dram_rd_addr_i[IDX_W+1:2];

  // Core store always wins; the host only gets the slot when the core is idle.
  always_comb begin
    w_buf_nxt = '0;
    if (w_core_act) begin
      if (!w_ovf) w_buf_nxt = '{1'b1, dram_wr_addr_i[IDX_W+1:2], w_data_s, w_be_s};
    end else if (w_host_hs) begin
      w_buf_nxt = '{1'b1, host_wr_addr_i[IDX_W+1:2], host_wr_data_i, BE_W};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf     <= '0;
      r_mis     <= 1'b0;
      r_mis_cnt <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      if (w_core_act && w_ovf) begin
        r_mis <= 1'b1;
        if (r_mis_cnt != 8'hFF) r_mis_cnt <= r_mis_cnt + 8'd1;
      end
    end
  end

  // Reset suppresses the commit so a pending entry is discarded.
  assign w_we_be = (r_buf.valid && !rst_i) ? r_buf.be : 4'b0000;

  // The RAM returns pre-commit data, so the buffered lanes are captured
  // alongside and overlaid on the RAM output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_be   <= (r_buf.valid && r_buf.idx == w_rd_idx) ? r_buf.be : 4'b0000;
      r_fwd_data <= r_buf.data;
    end
  end

  dram_resp_ram #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_we_be   (w_we_be),
    .i_wr_idx  (r_buf.idx),
    .i_wr_data (r_buf.data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_ram_q)
  );

  assign dram_rd_data_o = lane_merge(w_ram_q, r_fwd_data, r_fwd_be);
  assign misalign_o     = r_mis;
  assign misalign_cnt_o = r_mis_cnt;

  // Address bits outside the word index are intentionally ignored.
  logic w_unused_bits;
  assign w_unused_bits = ^{dram_rd_addr_i[XLEN-1:IDX_W+2], dram_rd_addr_i[1:0],
                           dram_wr_addr_i[XLEN-1:IDX_W+2],
                           host_wr_addr_i[XLEN-1:IDX_W+2], host_wr_addr_i[1:0]};

endmodule
